// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: per-domain clock-gate enable sequencer with settle-time ack and idle gate-off.
// Ports:
//   clk_i, rst_ni    - rising-edge clock, asynchronous active-low reset
//   test_en_i        - scan/test force-on of every clk_en_o bit (does not touch state or ack)
//   sw_en_i          - per-domain software enable request (level)
//   wake_req_i       - per-domain hardware wake request (level)
//   busy_i           - per-domain activity, only looked at while a domain is ON
//   idle_thresh_i    - idle cycles tolerated in ON before gate-off (timeout build only)
//   clk_en_o         - enable to each domain's clock-gate cell
//   ack_o            - domain clock running and settled
//   any_on_o         - OR of the registered enables, test force excluded
// Optional feature: define CLK_GATE_CTRL_IDLE_TIMEOUT_EN for ON-exit hysteresis via idle_thresh_i.
module clk_gate_ctrl #(
  parameter int NumDomains   = 4,
  parameter int SettleCycles = 2,
  parameter int IdleWidth    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_en_i,
  input  logic [NumDomains-1:0] sw_en_i,
  input  logic [NumDomains-1:0] wake_req_i,
  input  logic [NumDomains-1:0] busy_i,
  input  logic [IdleWidth-1:0]  idle_thresh_i,
  output logic [NumDomains-1:0] clk_en_o,
  output logic [NumDomains-1:0] ack_o,
  output logic                  any_on_o
);
  localparam int SW = SettleCycles > 1 ? $clog2(SettleCycles) : 1;
  typedef enum logic [1:0] {OFF, SETTLE, ON} state_e;
  logic [NumDomains-1:0] en_vec, ack_vec;
`ifndef CLK_GATE_CTRL_IDLE_TIMEOUT_EN
  logic unused_thresh;
  assign unused_thresh = ^idle_thresh_i;
`endif
  for (genvar i = 0; i < NumDomains; i++) begin : g_dom
    state_e        state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d, ack_q, ack_d;
    logic          req, idle;
`ifdef CLK_GATE_CTRL_IDLE_TIMEOUT_EN
    logic [IdleWidth-1:0] idle_cnt_q, idle_cnt_d;
`endif
    assign req  = sw_en_i[i] | wake_req_i[i];
    assign idle = !req && !busy_i[i];
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef CLK_GATE_CTRL_IDLE_TIMEOUT_EN
      idle_cnt_d = idle_cnt_q;
`endif
      unique case (state_q)
        OFF: if (req) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
        // SETTLE always completes, even if req drops meanwhile
        SETTLE: if (cnt_q == SW'(SettleCycles - 1)) begin
          state_d = ON;
`ifdef CLK_GATE_CTRL_IDLE_TIMEOUT_EN
          idle_cnt_d = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`ifdef CLK_GATE_CTRL_IDLE_TIMEOUT_EN
        // count is checked before increment, so threshold 0 exits on the first idle edge
        ON: if (!idle) idle_cnt_d = '0;
            else if (idle_cnt_q >= idle_thresh_i) state_d = OFF;
            else if (idle_cnt_q != '1) idle_cnt_d = idle_cnt_q + 1'b1;
`else
        ON: if (idle) state_d = OFF;
`endif
        default: state_d = OFF;
      endcase
      en_d  = state_d != OFF;
      ack_d = state_d == ON;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= OFF;
        cnt_q   <= '0;
        en_q    <= 1'b0;
        ack_q   <= 1'b0;
`ifdef CLK_GATE_CTRL_IDLE_TIMEOUT_EN
        idle_cnt_q <= '0;
`endif
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        en_q    <= en_d;
        ack_q   <= ack_d;
`ifdef CLK_GATE_CTRL_IDLE_TIMEOUT_EN
        idle_cnt_q <= idle_cnt_d;
`endif
      end
    end
    assign en_vec[i]  = en_q;
    assign ack_vec[i] = ack_q;
  end
  assign clk_en_o = en_vec | {NumDomains{test_en_i}};
  assign ack_o    = ack_vec;
  assign any_on_o = |en_vec;
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed self-checking bench for clk_gate_ctrl (4 domains, 2 settle cycles).
module tb_clk_gate_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       test_en;
  logic [3:0] sw_en, wake, busy, clk_en, ack;
  logic [7:0] thresh;
  logic       any_on;
  int         checks = 0;
  int         failures = 0;
  clk_gate_ctrl dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .test_en_i(test_en),
    .sw_en_i(sw_en),
    .wake_req_i(wake),
    .busy_i(busy),
    .idle_thresh_i(thresh),
    .clk_en_o(clk_en),
    .ack_o(ack),
    .any_on_o(any_on)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; test_en = 1'b0; sw_en = '0; wake = '0; busy = '0; thresh = '0;
    #2;
    check("rst_en", clk_en, 4'h0);
    check("rst_ack", ack, 4'h0);
    check("rst_any", any_on, 1'b0);
    test_en = 1'b1; #1;
    check("rst_test_en", clk_en, 4'hF);
    test_en = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("idle_en", clk_en, 4'h0);
    busy = 4'h8; tick();
    check("busy_in_off", clk_en, 4'h0);
    busy = '0;
    // wake + abort: single-cycle request on domain 0
    sw_en = 4'h1; tick();
    sw_en = '0;
    check("wake_en", clk_en, 4'h1);
    check("wake_ack0", ack, 4'h0);
    check("wake_any", any_on, 1'b1);
    tick();
    check("wake_ack1", ack, 4'h0);
    check("wake_en1", clk_en, 4'h1);
    tick();
    check("abort_ack_on", ack, 4'h1);
    check("abort_en_on", clk_en, 4'h1);
    tick();
    check("abort_off_en", clk_en, 4'h0);
    check("abort_off_ack", ack, 4'h0);
    // busy holds domain 1 on after request drops
    sw_en = 4'h2; tick(); tick(); tick();
    check("off_ack_on", ack, 4'h2);
    sw_en = '0; busy = 4'h2;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("off_busy_en", clk_en, 4'h2);
      check("off_busy_ack", ack, 4'h2);
    end
    busy = '0; tick();
    check("off_fall_en", clk_en, 4'h0);
    check("off_fall_ack", ack, 4'h0);
    // threshold on domain 2
    thresh = 8'd3;
    sw_en = 4'h4; tick(); tick(); tick();
    check("to_ack_on", ack, 4'h4);
    sw_en = '0;
`ifdef CLK_GATE_CTRL_IDLE_TIMEOUT_EN
    tick(); tick();
    check("to_hold_a", clk_en, 4'h4);
    busy = 4'h4; tick();
    busy = '0; tick(); tick(); tick();
    check("to_hold_b", clk_en, 4'h4);
    check("to_hold_ack", ack, 4'h4);
    tick();
    check("to_off_en", clk_en, 4'h0);
    check("to_off_ack", ack, 4'h0);
`else
    tick();
    check("nothr_off_en", clk_en, 4'h0);
    check("nothr_off_ack", ack, 4'h0);
`endif
    thresh = '0;
    // concurrent wake of all domains
    wake = 4'hF; tick();
    check("conc_en", clk_en, 4'hF);
    check("conc_any", any_on, 1'b1);
    check("conc_ack0", ack, 4'h0);
    tick();
    check("conc_ack1", ack, 4'h0);
    tick();
    check("conc_ack", ack, 4'hF);
    tick();
    check("conc_hold", ack, 4'hF);
    // asynchronous reset mid-cycle
    #3 rst_n = 1'b0; #1;
    check("arst_ack", ack, 4'h0);
    check("arst_en", clk_en, 4'h0);
    check("arst_any", any_on, 1'b0);
    test_en = 1'b1; #1;
    check("arst_test_en", clk_en, 4'hF);
    check("arst_test_ack", ack, 4'h0);
    test_en = 1'b0; wake = '0;
    tick();
    rst_n = 1'b1; tick();
    check("post_rst_en", clk_en, 4'h0);
    // test force does not touch FSM or ack
    test_en = 1'b1; tick(); tick(); tick();
    check("tf_en", clk_en, 4'hF);
    check("tf_any", any_on, 1'b0);
    check("tf_ack", ack, 4'h0);
    test_en = 1'b0; #1;
    check("tf_release", clk_en, 4'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 SHALL have parameter NumDomains, default 4: number of independently gated clock domains (1..32).
REQ-002 SHALL have parameter SettleCycles, default 2: cycles between gate enable and ack (minimum 1).
REQ-003 SHALL have parameter IdleWidth, default 8: width of the idle threshold and idle counter.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port test_en_i, input, 1 bit: scan/test force-on.
REQ-007 SHALL have port sw_en_i, input, NumDomains bits: per-domain software enable request, level.
REQ-008 SHALL have port wake_req_i, input, NumDomains bits: per-domain hardware wake request, level.
REQ-009 SHALL have port busy_i, input, NumDomains bits: per-domain activity indication.
REQ-010 SHALL have port idle_thresh_i, input, IdleWidth bits: idle cycles tolerated before gate-off.
REQ-011 SHALL have port clk_en_o, output, NumDomains bits: enable to each domain's clock-gate cell.
REQ-012 SHALL have port ack_o, output, NumDomains bits: domain clock running and settled.
REQ-013 SHALL have port any_on_o, output, 1 bit: OR of the registered per-domain enables.

Function
REQ-014 SHALL run one independent FSM per domain with states OFF, SETTLE, ON; req[i] = sw_en_i[i] | wake_req_i[i].
REQ-015 OFF: SHALL drive en=0 and ack=0; if req=1, SHALL go to SETTLE and clear the settle counter.
REQ-016 SETTLE: SHALL drive en=1 and ack=0; SHALL increment the settle counter each cycle and go to ON when it equals SettleCycles-1.
REQ-017 SETTLE SHALL NOT abort when req drops; the domain SHALL reach ON and then apply the ON exit rules.
REQ-018 ON: SHALL drive en=1 and ack=1; idle[i] = !req[i] & !busy_i[i].
REQ-019 en and ack SHALL be registered; req sampled high in OFF at edge t gives clk_en_o=1 after edge t and ack_o=1 after edge t+SettleCycles.
REQ-020 clk_en_o[i] SHALL be the registered enable OR test_en_i (combinational force); test_en_i SHALL NOT affect FSM state or ack_o.
REQ-021 busy_i SHALL be ignored in OFF and SETTLE.
REQ-022 Domains SHALL NOT interact; simultaneous transitions in several domains SHALL all take effect in the same cycle.
REQ-023 any_on_o SHALL be the OR of the registered enables, excluding test_en_i.

Reset
REQ-024 rst_ni low SHALL asynchronously force every FSM to OFF and clear all counters.
REQ-025 During reset, clk_en_o SHALL equal {NumDomains{test_en_i}} and ack_o and any_on_o SHALL be 0.
REQ-026 Reset asserted mid-SETTLE or mid-idle-count SHALL discard progress; after release, a domain SHALL restart from OFF.

Configuration
REQ-027 Macro CLK_GATE_CTRL_IDLE_TIMEOUT_EN SHALL control the ON-exit hysteresis.
REQ-028 Without the macro: ON SHALL go to OFF on the first edge where idle=1, and idle_thresh_i SHALL be unused.
REQ-029 With the macro: a saturating idle counter SHALL increment on each idle cycle in ON and clear on any non-idle cycle or on entering ON.
REQ-030 With the macro: ON SHALL go to OFF on an edge where idle=1 and idle_cnt >= idle_thresh_i; threshold 0 SHALL behave as without the macro.
REQ-031 With the macro: idle_thresh_i SHALL be sampled every cycle, and lowering it below the current count SHALL gate off on the next idle cycle.

Verification
REQ-032 Scenario, wake: reset, SettleCycles=2, pulse sw_en_i[0]=1 at edge 5 -> clk_en_o[0]=1 after edge 5, ack_o[0]=1 after edge 7, other domains remain 0.
REQ-033 Scenario, off: domain 1 ON, drop sw_en_i[1] with busy_i[1]=1 for 3 cycles then busy_i[1]=0 -> without the macro, en and ack fall one edge after busy drops.
REQ-034 Scenario, timeout: macro on, idle_thresh_i=3, domain 2 ON and idle from edge t -> gate-off after edge t+3; a busy pulse at t+2 restarts the count.
REQ-035 Scenario, abort: req dropped during SETTLE -> domain still reaches ON with ack_o=1, then goes OFF on the next idle edge (threshold 0).
REQ-036 Scenario, reset: rst_ni asserted asynchronously while all 4 domains are ON -> ack_o=0 and clk_en_o=0 immediately; with test_en_i=1, clk_en_o=4'hF.
REQ-037 Scenario, concurrent: all domains requested on the same edge -> all acks rise on the same cycle and any_on_o=1 one edge after the request.
